// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_OWNED   = 2'd2
  } arb_state_t;

  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int arb_id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner picker: rotate the request vector by the pointer,
// find the first set bit, then map the offset back to a channel index.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  localparam int IW1 = IW + 1;
  localparam logic [IW:0] N_W = IW1'(N);

  logic [IW-1:0]  base;
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW:0]    offset;
  logic [IW:0]    sum;

  // Fixed priority is just a rotation by zero.
  assign base    = mode ? ptr : '0;
  assign doubled = {req, req} >> base;
  assign rotated = doubled[N-1:0];
  assign any     = |req;

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = IW1'(i);
    end
    sum = {1'b0, base} + offset;
    if (sum >= N_W) sum = sum - N_W;
  end

  assign winner_idx = sum[IW-1:0];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign winner[gi] = any && (winner_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel bus arbiter: registered one-hot grant, busy-based ownership,
// hold-limit preemption request and sticky protocol-error flag.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int MODE_RR      = 1,
  parameter int MAX_HOLD     = 0,
  parameter int ID_WIDTH     = arb_id_width(NUM_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [NUM_CHANNELS-1:0] busy,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic                    grant_valid,
  output logic [ID_WIDTH-1:0]     grant_id,
  output logic                    preempt,
  output logic                    protocol_err
);

  localparam int HW = arb_id_width(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_CHANNELS - 1);
  localparam logic PICK_MODE = (MODE_RR != 0) ? ARB_MODE_RR : ARB_MODE_FIXED;

  arb_state_t              state_reg;
  logic [NUM_CHANNELS-1:0] grant_reg;
  logic [ID_WIDTH-1:0]     grant_id_reg;
  logic [ID_WIDTH-1:0]     ptr_reg;
  logic [HW-1:0]           hold_reg;
  logic                    preempt_reg;
  logic                    err_reg;
  logic                    released_reg;

  logic [NUM_CHANNELS-1:0] pick_onehot;
  logic [ID_WIDTH-1:0]     pick_idx;
  logic                    pick_any;

  logic [NUM_CHANNELS-1:0] last_onehot;
  logic [NUM_CHANNELS-1:0] busy_ok;
  logic                    owner_busy;
  logic                    owner_req;
  logic                    others_req;
  logic                    violation;
  logic [HW-1:0]           hold_next;
  logic                    preempt_hit;

  rr_picker #(
    .N  (NUM_CHANNELS),
    .IW (ID_WIDTH)
  ) u_picker (
    .req        (req),
    .ptr        (ptr_reg),
    .mode       (PICK_MODE),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_last
      assign last_onehot[gi] = (grant_id_reg == ID_WIDTH'(gi));
    end
  endgenerate

  // The previous owner may still show busy in the first free cycle after release.
  assign busy_ok     = grant_reg | (released_reg ? last_onehot : '0);
  assign violation   = |(busy & ~busy_ok);
  assign owner_busy  = |(busy & grant_reg);
  assign owner_req   = |(req & grant_reg);
  assign others_req  = |(req & ~grant_reg);
  assign hold_next   = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + 1'b1;
  assign preempt_hit = (MAX_HOLD != 0) && (hold_next == HOLD_MAX) && others_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ARB_IDLE;
      grant_reg    <= '0;
      grant_id_reg <= '0;
      ptr_reg      <= '0;
      hold_reg     <= '0;
      preempt_reg  <= 1'b0;
      err_reg      <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      err_reg      <= err_reg | violation;
      released_reg <= 1'b0;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_reg    <= pick_onehot;
            grant_id_reg <= pick_idx;
            state_reg    <= ARB_GRANTED;
          end
        end
        ARB_GRANTED: begin
          if (owner_busy) begin
            state_reg <= ARB_OWNED;
            hold_reg  <= '0;
          end else if (!owner_req) begin
            // Abandoned before use: pointer stays put.
            grant_reg <= '0;
            state_reg <= ARB_IDLE;
          end
        end
        ARB_OWNED: begin
          if (owner_busy) begin
            hold_reg <= hold_next;
            if (preempt_hit) preempt_reg <= 1'b1;
          end else begin
            grant_reg    <= '0;
            state_reg    <= ARB_IDLE;
            preempt_reg  <= 1'b0;
            hold_reg     <= '0;
            released_reg <= 1'b1;
            ptr_reg      <= (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ARB_IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  assign grant        = grant_reg;
  assign grant_valid  = |grant_reg;
  assign grant_id     = grant_id_reg;
  assign preempt      = preempt_reg;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: three configurations driven side by side, checked
// every cycle against a behavioural owner/queue model plus directed scenarios.
`timescale 1ns/1ps
module tb_bus_arbiter_rr;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] req_v  [NI];
  logic [15:0] busy_v [NI];

  logic [2:0] grant0, grant1;
  logic [4:0] grant2;
  logic       gv0, gv1, gv2;
  logic [1:0] gid0, gid1;
  logic [2:0] gid2;
  logic       pre0, pre1, pre2;
  logic       err0, err1, err2;

  bus_arbiter_rr #(.NUM_CHANNELS(3), .MODE_RR(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .reset(reset), .req(req_v[0][2:0]), .busy(busy_v[0][2:0]),
    .grant(grant0), .grant_valid(gv0), .grant_id(gid0), .preempt(pre0), .protocol_err(err0));

  bus_arbiter_rr #(.NUM_CHANNELS(3), .MODE_RR(0), .MAX_HOLD(0)) u_fix (
    .clk(clk), .reset(reset), .req(req_v[1][2:0]), .busy(busy_v[1][2:0]),
    .grant(grant1), .grant_valid(gv1), .grant_id(gid1), .preempt(pre1), .protocol_err(err1));

  bus_arbiter_rr #(.NUM_CHANNELS(5), .MODE_RR(1), .MAX_HOLD(2)) u_n5 (
    .clk(clk), .reset(reset), .req(req_v[2][4:0]), .busy(busy_v[2][4:0]),
    .grant(grant2), .grant_valid(gv2), .grant_id(gid2), .preempt(pre2), .protocol_err(err2));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: who owns the bus, whether it is in use, and for how long.
  bit m_granted [NI];
  bit m_using   [NI];
  int m_owner   [NI];
  int m_held    [NI];
  int m_start   [NI];
  int m_last    [NI];
  bit m_pre     [NI];
  bit m_err     [NI];
  bit m_after   [NI];
  int left      [NI];

  function automatic int nch(input int i);
    return (i == 2) ? 5 : 3;
  endfunction

  function automatic bit is_rr(input int i);
    return i != 1;
  endfunction

  function automatic int hold_lim(input int i);
    return (i == 0) ? 4 : ((i == 2) ? 2 : 0);
  endfunction

  function automatic logic [15:0] mask(input int n);
    return (16'(1) << n) - 16'(1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i, input logic [15:0] r, input logic [15:0] b, input bit rst);
    int  n;
    bit  viol;
    bit  rel_now;
    int  c;
    int  cand;
    n = nch(i);
    if (rst) begin
      m_granted[i] = 0; m_using[i] = 0; m_owner[i] = 0; m_held[i] = 0;
      m_start[i] = 0; m_last[i] = 0; m_pre[i] = 0; m_err[i] = 0; m_after[i] = 0;
      return;
    end
    viol = 0;
    for (int j = 0; j < n; j++) begin
      if (b[j] && !(m_granted[i] && m_owner[i] == j) && !(m_after[i] && m_last[i] == j))
        viol = 1;
    end
    if (viol) m_err[i] = 1;
    rel_now = 0;
    if (!m_granted[i]) begin
      if ((r & mask(n)) != 16'h0) begin
        c = -1;
        for (int k = 0; k < n; k++) begin
          cand = is_rr(i) ? (m_start[i] + k) % n : k;
          if (c < 0 && r[cand]) c = cand;
        end
        m_owner[i] = c; m_granted[i] = 1; m_using[i] = 0; m_last[i] = c;
      end
    end else if (!m_using[i]) begin
      if (b[m_owner[i]]) begin
        m_using[i] = 1; m_held[i] = 0;
      end else if (!r[m_owner[i]]) begin
        m_granted[i] = 0;
      end
    end else begin
      if (!b[m_owner[i]]) begin
        rel_now = 1;
        m_granted[i] = 0; m_using[i] = 0; m_pre[i] = 0; m_held[i] = 0;
        m_start[i] = (m_owner[i] + 1) % n;
      end else begin
        if (m_held[i] < hold_lim(i)) m_held[i]++;
        if (hold_lim(i) != 0 && m_held[i] == hold_lim(i) &&
            ((r & mask(n) & ~(16'(1) << m_owner[i])) != 16'h0))
          m_pre[i] = 1;
      end
    end
    m_after[i] = rel_now;
  endtask

  task automatic get_dut(input int i, output logic [15:0] g, output logic gv,
                         output logic [15:0] gid, output logic p, output logic e);
    case (i)
      0: begin g = 16'(grant0); gv = gv0; gid = 16'(gid0); p = pre0; e = err0; end
      1: begin g = 16'(grant1); gv = gv1; gid = 16'(gid1); p = pre1; e = err1; end
      default: begin g = 16'(grant2); gv = gv2; gid = 16'(gid2); p = pre2; e = err2; end
    endcase
  endtask

  task automatic compare_all();
    logic [15:0] g, gid, exp_g;
    logic gv, p, e;
    for (int i = 0; i < NI; i++) begin
      get_dut(i, g, gv, gid, p, e);
      exp_g = m_granted[i] ? (16'(1) << m_owner[i]) : 16'h0;
      check_eq($sformatf("i%0d.grant", i), 32'(g), 32'(exp_g));
      check_eq($sformatf("i%0d.grant_valid", i), 32'(gv), 32'(m_granted[i]));
      check_eq($sformatf("i%0d.grant_id", i), 32'(gid), 32'(m_last[i]));
      check_eq($sformatf("i%0d.preempt", i), 32'(p), 32'(m_pre[i]));
      check_eq($sformatf("i%0d.protocol_err", i), 32'(e), 32'(m_err[i]));
    end
  endtask

  task automatic tick(input bit rst);
    reset = rst;
    for (int i = 0; i < NI; i++) model_step(i, req_v[i], busy_v[i], rst);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      req_v[i] = 16'h0; busy_v[i] = 16'h0; left[i] = 0;
    end
  endtask

  // Well-behaved owner: raise busy as soon as granted, keep it for len cycles.
  task automatic drive_owner(input int i, input int len);
    busy_v[i] = 16'h0;
    if (m_granted[i]) begin
      if (!m_using[i]) begin
        busy_v[i] = 16'(1) << m_owner[i];
        left[i] = len - 1;
      end else if (left[i] > 0) begin
        busy_v[i] = 16'(1) << m_owner[i];
        left[i]--;
      end
    end
  endtask

  task automatic random_drive(input int i);
    int n;
    logic [15:0] r, b;
    n = nch(i);
    r = 16'($urandom) & 16'($urandom) & mask(n);
    b = 16'h0;
    if (m_granted[i]) begin
      if (!m_using[i]) begin
        if ($urandom_range(0, 9) < 6) begin
          b = 16'(1) << m_owner[i];
          r[m_owner[i]] = 1'b1;
          left[i] = $urandom_range(0, 8);
        end else if ($urandom_range(0, 3) != 0) begin
          r[m_owner[i]] = 1'b1;
        end
      end else if (left[i] > 0) begin
        b = 16'(1) << m_owner[i];
        left[i]--;
      end
    end
    if ($urandom_range(0, 79) == 0) b[$urandom_range(0, n - 1)] = 1'b1;
    req_v[i] = r;
    busy_v[i] = b;
  endtask

  int seen_gid[$];
  int exp_seq[4] = '{0, 1, 2, 0};
  int idle_run;
  bit prev_gv0;
  bit prev_g1;
  int ch1_grants;
  int ch2_grants;

  initial begin
    clear_inputs();
    tick(1);
    tick(1);

    // Round-robin order with 2-cycle ownership, and fixed-priority starvation.
    req_v[0] = 16'h7;
    req_v[1] = 16'h6;
    idle_run = 0; prev_gv0 = 0; prev_g1 = 0; ch1_grants = 0; ch2_grants = 0;
    for (int c = 0; c < 40; c++) begin
      drive_owner(0, 2);
      drive_owner(1, 1);
      tick(0);
      if (c == 0) check_eq("p1.latency", 32'(grant0), 32'd1);
      if (gv0 && !prev_gv0) begin
        seen_gid.push_back(int'(gid0));
        if (seen_gid.size() > 1) check_eq("p1.idle_gap", 32'(idle_run), 32'd1);
      end
      idle_run = gv0 ? 0 : idle_run + 1;
      prev_gv0 = gv0;
      if (grant1[2]) ch2_grants++;
      if (grant1[1] && !prev_g1) ch1_grants++;
      prev_g1 = grant1[1];
    end
    check_eq("p1.grant_count_ge4", 32'(seen_gid.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < seen_gid.size(); k++)
      check_eq($sformatf("p1.order%0d", k), 32'(seen_gid[k]), 32'(exp_seq[k]));
    check_eq("p1.fixed_ch1_ge5", 32'(ch1_grants >= 5), 32'd1);
    check_eq("p1.fixed_ch2_starved", 32'(ch2_grants), 32'd0);

    // Hold limit: preempt after the 4th owned cycle, grant kept until release.
    clear_inputs();
    tick(1);
    req_v[0] = 16'h1;
    tick(0);
    check_eq("p2.grant_ch0", 32'(grant0), 32'd1);
    busy_v[0] = 16'h1;
    tick(0);
    req_v[0] = 16'h5;
    for (int k = 2; k <= 7; k++) begin
      tick(0);
      if (k == 4) check_eq("p2.preempt_before", 32'(pre0), 32'd0);
      if (k >= 5) check_eq($sformatf("p2.preempt_c%0d", k), 32'(pre0), 32'd1);
      check_eq($sformatf("p2.grant_kept_c%0d", k), 32'(grant0), 32'd1);
    end
    busy_v[0] = 16'h0;
    tick(0);
    check_eq("p2.idle_after_release", 32'(grant0), 32'd0);
    check_eq("p2.preempt_cleared", 32'(pre0), 32'd0);
    tick(0);
    check_eq("p2.next_is_ch2", 32'(grant0), 32'd4);

    // Abandoned grant leaves the pointer alone; former owner's busy tolerated once.
    clear_inputs();
    tick(1);
    req_v[0] = 16'h1;
    tick(0);
    busy_v[0] = 16'h1; req_v[0] = 16'h0;
    tick(0);
    busy_v[0] = 16'h0;
    tick(0);
    check_eq("p3.released", 32'(gv0), 32'd0);
    req_v[0] = 16'h2; busy_v[0] = 16'h1;
    tick(0);
    check_eq("p3.grant_ch1", 32'(grant0), 32'd2);
    check_eq("p3.release_exception", 32'(err0), 32'd0);
    req_v[0] = 16'h0; busy_v[0] = 16'h0;
    tick(0);
    check_eq("p3.abandon_drop", 32'(grant0), 32'd0);
    req_v[0] = 16'h3;
    tick(0);
    check_eq("p3.regrant_ch1", 32'(grant0), 32'd2);
    check_eq("p3.regrant_id", 32'(gid0), 32'd1);
    req_v[0] = 16'h0;
    tick(0);

    // Sticky protocol error.
    clear_inputs();
    tick(1);
    req_v[0] = 16'h1;
    tick(0);
    busy_v[0] = 16'h4;
    tick(0);
    check_eq("p4.err_set", 32'(err0), 32'd1);
    busy_v[0] = 16'h0;
    req_v[0] = 16'h7;
    for (int c = 0; c < 20; c++) begin
      drive_owner(0, 2);
      tick(0);
    end
    check_eq("p4.err_sticky", 32'(err0), 32'd1);
    clear_inputs();
    tick(1);
    check_eq("p4.err_reset", 32'(err0), 32'd0);

    // Reset during ownership on the 5-channel instance.
    req_v[2] = 16'h1;
    tick(0);
    busy_v[2] = 16'h1;
    tick(0);
    tick(0);
    check_eq("p5.owned_grant", 32'(grant2), 32'd1);
    tick(1);
    check_eq("p5.rst_grant", 32'(grant2), 32'd0);
    check_eq("p5.rst_valid", 32'(gv2), 32'd0);
    check_eq("p5.rst_id", 32'(gid2), 32'd0);
    busy_v[2] = 16'h0; req_v[2] = 16'h10;
    tick(0);
    check_eq("p5.grant_ch4", 32'(grant2), 32'h10);
    check_eq("p5.id_ch4", 32'(gid2), 32'd4);

    // Randomized traffic with occasional resets and stray busy bits.
    clear_inputs();
    tick(1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) random_drive(i);
      tick($urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised N-channel bus arbiter; successor to the fixed 3-requester bus_controller in top.
- Requesters raise req, receive a registered one-hot grant, assert busy while they own the shared bus, then drop busy to release.
- Adds round-robin or fixed-priority mode, a hold-limit preemption request and a sticky protocol-error flag.
- Sits between the VA→PA walker, the load/store data paths and the Sysbus interface logic in top.

Parameters:
NUM_CHANNELS, 3, number of requesters (2..16)
MODE_RR, 1, 1 = round-robin; 0 = fixed priority, channel 0 highest
MAX_HOLD, 0, owned cycles before preempt is raised when others wait; 0 = unlimited
ID_WIDTH, $clog2(NUM_CHANNELS), derived; width of grant_id

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high
req  input  NUM_CHANNELS  per-channel bus request, level
busy  input  NUM_CHANNELS  per-channel "using bus", level; only meaningful from the granted channel
grant  output  NUM_CHANNELS  registered one-hot grant; all-zero when free
grant_valid  output  1  OR of grant
grant_id  output  ID_WIDTH  index of granted channel; holds last value when free
preempt  output  1  owner must finish and drop busy; level
protocol_err  output  1  sticky; busy seen from a non-granted channel

Behaviour:
- Reset (sampled at posedge):
  - grant=0, grant_valid=0, grant_id=0, preempt=0, protocol_err=0.
  - rr pointer=0, hold counter=0, state=IDLE.
  - Reset mid-ownership drops grant at that edge; no completion of the transfer.
- States:
  - IDLE: grant=0. If any req bit is set at edge k, the winner is picked and the grant is registered at edge k (visible in cycle k+1) → GRANTED. Request-to-grant latency is 1 cycle.
  - GRANTED: grant held.
    - busy[id]=1 → OWNED, hold counter cleared.
    - req[id]=0 and busy[id]=0 → IDLE (abandoned request); grant drops next edge; rr pointer is not advanced.
  - OWNED: grant held while busy[id]=1.
    - Hold counter increments each cycle and saturates at MAX_HOLD.
    - When busy[id] falls → IDLE. grant drops at that edge. preempt and the counter clear. Pointer = (id+1) mod NUM_CHANNELS.
- Turnaround: IDLE always lasts at least 1 cycle between owners, even if req is pending when busy falls. No back-to-back grant.
- Winner selection:
  - RR: first set req bit searching upward from the pointer, wrapping past NUM_CHANNELS-1 to 0.
  - Fixed: lowest set index; the pointer is maintained but unused.
- preempt:
  - Raised when MAX_HOLD≠0, the counter has reached MAX_HOLD, and any req[j] (j≠id) is set.
  - Stays high until busy[id] falls. The grant is never forcibly removed.
  - If the other requests withdraw, preempt stays asserted once raised.
- protocol_err:
  - Set when busy[j]=1 for any j with grant[j]=0.
  - Exception: the same cycle that grant drops after the owner's own release does not count.
  - Cleared only by reset.
- busy[id]=1 in the same cycle that grant is issued is impossible (grant is registered); busy[id] is evaluated from GRANTED onward.
- req from the owner during OWNED is ignored; the owner re-arbitrates after release.

Decomposition:
- Package bus_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_GRANTED, ARB_OWNED}
  - mode constants ARB_MODE_FIXED=0, ARB_MODE_RR=1
  - helper function for ID_WIDTH with minimum 1
- Sub-module rr_picker (combinational): inputs req vector, pointer, mode; outputs one-hot winner, winner index, any. Implemented as a double-width rotate / find-first / unrotate. The arbiter instantiates one.

Test Plan:
- Reset then req=3'b111, MODE_RR=1, each owner holds busy 2 cycles → grants in order ch0, ch1, ch2, ch0, with exactly 1 idle cycle between them; grant_id 0,1,2,0.
- MODE_RR=0, req=3'b110 continuously, owners release after 1 cycle → ch1 is granted every time; ch2 is never granted (starvation is the expected result in fixed mode).
- MAX_HOLD=4, ch0 owns with busy held, req[2] rises at owned cycle 1 → preempt rises after the 4th owned cycle. The grant stays until ch0 drops busy. The next grant is ch2, after 1 idle cycle.
- Grant ch1, then req[1] drops before busy → grant returns to 0 next cycle. The pointer is unchanged, so the next req=3'b011 grants ch1 again.
- busy[2]=1 while ch0 is granted → protocol_err=1 from the next cycle and stays 1 through further traffic until reset.
- Assert reset during OWNED with NUM_CHANNELS=5 → all outputs 0 after the edge. The next req=5'b10000 is granted to ch4 with 1-cycle latency.
